// File: rtl/ifu_pkg.sv
// ifu_pkg: shared states and constants
// for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_ADDR = 3'd1,
    IFU_DATA = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_DROP = 3'd4
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] NOP_DEFAULT =
    32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch
// between the PC unit and the IF/ID register.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        pc_b_j,
  input  logic        if_id_stall,
  input  logic        if_id_ready,
  output logic        if_busy,
  output logic        inst_ar_valid,
  output logic [31:0] inst_ar_addr,
  input  logic        inst_ar_ready,
  input  logic        inst_r_valid,
  input  logic [31:0] inst_r_data,
  input  logic [1:0]  inst_r_resp,
  output logic        inst_r_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault
);

  ifu_state_e  state;
  ifu_state_e  state_d;
  logic [31:0] req_pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic        go;
  logic        rsp_err;

  assign go           = if_id_ready && !if_id_stall;
  assign rsp_err      = inst_r_resp != RESP_OKAY;
  assign inst_ar_addr = req_pc;

  // Next state; a redirect always wins over
  // delivering or accepting an instruction.
  always_comb begin
    state_d = state;
    unique case (state)
      IFU_IDLE: begin
        if (go)
          state_d = IFU_ADDR;
      end
      IFU_ADDR: begin
        if (inst_ar_ready)
          state_d = (pc_b_j || pend) ?
                    IFU_DROP : IFU_DATA;
      end
      IFU_DATA: begin
        if (inst_r_valid)
          state_d = pc_b_j ?
                    IFU_ADDR : IFU_HOLD;
        else if (pc_b_j)
          state_d = IFU_DROP;
      end
      IFU_HOLD: begin
        if (pc_b_j)
          state_d = IFU_ADDR;
        else if (go)
          state_d = IFU_IDLE;
      end
      IFU_DROP: begin
        if (inst_r_valid)
          state_d = IFU_ADDR;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  // State, decoded-then-registered handshakes,
  // request/pending PCs and the IF/ID bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IFU_IDLE;
      if_busy       <= 1'b0;
      inst_ar_valid <= 1'b0;
      inst_r_ready  <= 1'b0;
      if_valid      <= 1'b0;
      if_fault      <= 1'b0;
      if_pc         <= '0;
      if_inst       <= '0;
      req_pc        <= '0;
      pend_pc       <= '0;
      pend          <= 1'b0;
    end else begin
      state         <= state_d;
      if_busy       <= state_d != IFU_IDLE;
      inst_ar_valid <= state_d == IFU_ADDR;
      inst_r_ready  <= (state_d == IFU_DATA) ||
                       (state_d == IFU_DROP);
      if_valid      <= state_d == IFU_HOLD;
      unique case (state)
        IFU_IDLE: begin
          if (go)
            req_pc <= pc;
        end
        IFU_ADDR: begin
          if (pc_b_j) begin
            pend    <= 1'b1;
            pend_pc <= pc;
          end
        end
        IFU_DATA: begin
          if (inst_r_valid) begin
            if (pc_b_j) begin
              req_pc <= pc;
            end else begin
              if_pc    <= req_pc;
              if_fault <= rsp_err;
              if_inst  <= rsp_err ?
                          NOP_INST : inst_r_data;
            end
          end else if (pc_b_j) begin
            pend    <= 1'b1;
            pend_pc <= pc;
          end
        end
        IFU_HOLD: begin
          if (pc_b_j)
            req_pc <= pc;
        end
        IFU_DROP: begin
          if (pc_b_j)
            pend_pc <= pc;
          if (inst_r_valid) begin
            pend   <= 1'b0;
            req_pc <= pc_b_j ? pc : pend_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
